// File: rtl/vend_pkg.sv
// Shared types and defaults for the keypad vending sequence matcher.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_MATCH   = 2'd2,
        ST_CLEAR   = 2'd3
    } state_e;

    localparam int unsigned DEF_KEY_W     = 6;
    localparam int unsigned DEF_NUM_ITEMS = 4;
    localparam int unsigned DEF_SEQ_LEN   = 2;

    localparam logic [DEF_KEY_W-1:0] DEF_CLR_KEY = 6'b110111;

    // Item i, position p lives at bits [(i*SEQ_LEN+p)*KEY_W +: KEY_W]; MSB-first here.
    localparam logic [DEF_NUM_ITEMS*DEF_SEQ_LEN*DEF_KEY_W-1:0] DEF_CODE_TABLE = {
        6'b101011, 6'b100111,
        6'b011101, 6'b011011,
        6'b010111, 6'b001101,
        6'b001011, 6'b000111
    };

endpackage

// File: rtl/vend_timeout.sv
// Inter-key idle counter; expire_o goes high once TIMEOUT_CYC enabled cycles pass without a clear.
module vend_timeout #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expire_q;

    // Saturating count so a stalled expiry cannot wrap back to zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= (count_d == CNT_MAX);
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/vend_sequence.sv
// Multi-key item code matcher: narrows a candidate mask key by key and reports the selected item.
module vend_sequence
    import vend_pkg::*;
#(
    parameter int unsigned       KEY_W       = DEF_KEY_W,
    parameter int unsigned       NUM_ITEMS   = DEF_NUM_ITEMS,
    parameter int unsigned       SEQ_LEN     = DEF_SEQ_LEN,
    parameter int unsigned       TIMEOUT_CYC = 1000,
    parameter logic [KEY_W-1:0]  CLR_KEY     = KEY_W'(DEF_CLR_KEY)
) (
    input  logic                              clk,
    input  logic                              clr_n,
    input  logic [KEY_W-1:0]                  key,
    input  logic                              key_valid,
    input  logic [NUM_ITEMS*SEQ_LEN*KEY_W-1:0] code_table,
    output logic [NUM_ITEMS-1:0]              item_sel,
    output logic                              item_valid,
    output logic                              reset_out,
    output logic                              seq_err,
    output logic                              busy
);

    localparam int unsigned IDX_W = $clog2(SEQ_LEN) + 1;

    state_e                 state_q, state_d;
    logic [NUM_ITEMS-1:0]   mask_q, mask_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_ITEMS-1:0]   item_sel_q, item_sel_d;
    logic                   item_valid_q, item_valid_d;
    logic                   reset_out_q, reset_out_d;
    logic                   seq_err_q, seq_err_d;
    logic                   busy_q, busy_d;

    logic [NUM_ITEMS-1:0]   start_mask_c;
    logic [NUM_ITEMS-1:0]   pos_mask_c;
    logic [NUM_ITEMS-1:0]   narrow_mask_c;
    logic                   is_clr_c;
    logic                   is_start_c;
    logic                   tmo_clear;
    logic                   tmo_enable;
    logic                   tmo_expire;

    // Isolate the lowest set bit: m & -m.
    function automatic logic [NUM_ITEMS-1:0] lowest_onehot(input logic [NUM_ITEMS-1:0] m);
        return m & (~m + NUM_ITEMS'(1));
    endfunction

    // Compare the key against position 0 and against the current position of every item.
    always_comb begin
        start_mask_c = '0;
        pos_mask_c   = '0;
        for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            start_mask_c[i] = (code_table[(i * int'(SEQ_LEN)) * int'(KEY_W) +: KEY_W] == key);
            pos_mask_c[i]   = (code_table[(i * int'(SEQ_LEN) + int'(idx_q)) * int'(KEY_W) +: KEY_W] == key);
        end
    end

    assign is_clr_c      = (key == CLR_KEY);
    assign is_start_c    = |start_mask_c;
    assign narrow_mask_c = mask_q & pos_mask_c;

    assign tmo_clear  = key_valid | (state_q != ST_COLLECT);
    assign tmo_enable = (state_q == ST_COLLECT);

    vend_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (clr_n),
        .clear_i  (tmo_clear),
        .enable_i (tmo_enable),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        idx_d        = idx_q;
        item_sel_d   = item_sel_q;
        item_valid_d = 1'b0;
        seq_err_d    = 1'b0;

        if (key_valid && is_clr_c) begin
            state_d    = ST_CLEAR;
            mask_d     = '0;
            idx_d      = '0;
            item_sel_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_MATCH, ST_CLEAR: begin
                    if (key_valid && is_start_c) begin
                        mask_d     = start_mask_c;
                        idx_d      = IDX_W'(1);
                        item_sel_d = '0;
                        if (SEQ_LEN == 1) begin
                            state_d      = ST_MATCH;
                            item_sel_d   = lowest_onehot(start_mask_c);
                            item_valid_d = 1'b1;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (key_valid) begin
                        if (narrow_mask_c == '0) begin
                            state_d   = ST_IDLE;
                            mask_d    = '0;
                            idx_d     = '0;
                            seq_err_d = 1'b1;
                        end else begin
                            mask_d = narrow_mask_c;
                            idx_d  = idx_q + IDX_W'(1);
                            if ((idx_q + IDX_W'(1)) == IDX_W'(SEQ_LEN)) begin
                                state_d      = ST_MATCH;
                                item_sel_d   = lowest_onehot(narrow_mask_c);
                                item_valid_d = 1'b1;
                            end
                        end
                    end else if (tmo_expire) begin
                        state_d   = ST_IDLE;
                        mask_d    = '0;
                        idx_d     = '0;
                        seq_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        reset_out_d = (state_d == ST_CLEAR);
        busy_d      = (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            idx_q        <= '0;
            item_sel_q   <= '0;
            item_valid_q <= 1'b0;
            reset_out_q  <= 1'b0;
            seq_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            item_sel_q   <= item_sel_d;
            item_valid_q <= item_valid_d;
            reset_out_q  <= reset_out_d;
            seq_err_q    <= seq_err_d;
            busy_q       <= busy_d;
        end
    end

    assign item_sel   = item_sel_q;
    assign item_valid = item_valid_q;
    assign reset_out  = reset_out_q;
    assign seq_err    = seq_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vend_sequence.sv
// Directed bench for vend_sequence with the default 4-item, 2-key code table.
module tb_vend_sequence;

    localparam int unsigned TMO = 1000;

    logic        clk;
    logic        clr_n;
    logic [5:0]  key;
    logic        key_valid;
    logic [47:0] code_table;
    logic [3:0]  item_sel;
    logic        item_valid;
    logic        reset_out;
    logic        seq_err;
    logic        busy;
    logic [7:0]  obs;

    int total;
    int bad;

    typedef struct {
        logic       kv;
        logic [5:0] k;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [20];

    vend_sequence dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .key        (key),
        .key_valid  (key_valid),
        .code_table (code_table),
        .item_sel   (item_sel),
        .item_valid (item_valid),
        .reset_out  (reset_out),
        .seq_err    (seq_err),
        .busy       (busy)
    );

    // Observed bundle: {item_sel[3:0], item_valid, reset_out, seq_err, busy}.
    assign obs = {item_sel, item_valid, reset_out, seq_err, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic press(input logic [5:0] k);
        @(negedge clk);
        key       = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        code_table = {6'b101011, 6'b100111, 6'b011101, 6'b011011,
                      6'b010111, 6'b001101, 6'b001011, 6'b000111};
        clr_n     = 1'b0;
        key       = '0;
        key_valid = 1'b0;

        vecs[0]  = '{1'b0, 6'b000000, 8'b0000_0000};
        vecs[1]  = '{1'b1, 6'b000111, 8'b0000_0001};
        vecs[2]  = '{1'b1, 6'b001011, 8'b0001_1000};
        vecs[3]  = '{1'b0, 6'b000000, 8'b0001_0000};
        vecs[4]  = '{1'b1, 6'b010111, 8'b0001_0000};
        vecs[5]  = '{1'b1, 6'b011011, 8'b0000_0001};
        vecs[6]  = '{1'b1, 6'b101011, 8'b0000_0010};
        vecs[7]  = '{1'b0, 6'b000000, 8'b0000_0000};
        vecs[8]  = '{1'b1, 6'b011011, 8'b0000_0001};
        vecs[9]  = '{1'b1, 6'b011101, 8'b0100_1000};
        vecs[10] = '{1'b1, 6'b110111, 8'b0000_0100};
        vecs[11] = '{1'b1, 6'b000000, 8'b0000_0100};
        vecs[12] = '{1'b1, 6'b001101, 8'b0000_0001};
        vecs[13] = '{1'b1, 6'b010111, 8'b0010_1000};
        vecs[14] = '{1'b1, 6'b100111, 8'b0000_0001};
        vecs[15] = '{1'b1, 6'b110111, 8'b0000_0100};
        vecs[16] = '{1'b1, 6'b100111, 8'b0000_0001};
        vecs[17] = '{1'b1, 6'b100111, 8'b0000_0010};
        vecs[18] = '{1'b1, 6'b001011, 8'b0000_0000};
        vecs[19] = '{1'b0, 6'b000111, 8'b0000_0000};

        #3;
        check("reset_state", obs, 8'b0000_0000);
        @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            key       = vecs[i].k;
            key_valid = vecs[i].kv;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
            key_valid = 1'b0;
        end

        // Timeout with no further key: abort one cycle after the counter saturates.
        press(6'b100111);
        check("tmo_start", obs, 8'b0000_0001);
        repeat (TMO) @(posedge clk);
        #1;
        check("tmo_before_expiry", obs, 8'b0000_0001);
        @(posedge clk);
        #1;
        check("tmo_expired", obs, 8'b0000_0010);
        @(posedge clk);
        #1;
        check("tmo_err_one_pulse", obs, 8'b0000_0000);

        // Key arriving in the expiry cycle wins over the timeout.
        press(6'b100111);
        repeat (TMO) @(posedge clk);
        @(negedge clk);
        key       = 6'b101011;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("tmo_key_on_expiry", obs, 8'b1000_1000);
        @(posedge clk);
        #1;
        check("match_held", obs, 8'b1000_0000);

        // Asynchronous reset mid-sequence, then a lone second key is ignored.
        press(6'b001101);
        check("pre_reset_collect", obs, 8'b0000_0001);
        @(negedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        check("async_reset", obs, 8'b0000_0000);
        @(negedge clk);
        clr_n = 1'b1;
        press(6'b010111);
        check("after_reset_lone_key", obs, 8'b0000_0000);

        // Key presented with reset release is taken on the first rising edge.
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n     = 1'b1;
        key       = 6'b000111;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("first_edge_after_reset", obs, 8'b0000_0001);
        press(6'b001011);
        check("first_edge_complete", obs, 8'b0001_1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_sequence.md
VEND_SEQUENCE -- requirements
Module: vend_sequence

Interface
REQ-001 SHALL have parameter KEY_W, 6, key code width in bits.
REQ-002 SHALL have parameter NUM_ITEMS, 4, number of selectable items (>=1).
REQ-003 SHALL have parameter SEQ_LEN, 2, keys per item code (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYC, 1000, idle cycles allowed between keys mid-sequence (>=1).
REQ-005 SHALL have parameter CLR_KEY, 6'b110111, clear key code.
REQ-006 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 SHALL have port clr_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port key  input  KEY_W  key code, sampled only when key_valid=1.
REQ-009 SHALL have port key_valid  input  1  one-cycle strobe per key press.
REQ-010 SHALL have port code_table  input  NUM_ITEMS*SEQ_LEN*KEY_W  static code table; item i, position p at bits [(i*SEQ_LEN+p)*KEY_W +: KEY_W].
REQ-011 SHALL have port item_sel  output  NUM_ITEMS  one-hot selected item, held in MATCH.
REQ-012 SHALL have port item_valid  output  1  one-cycle pulse on entry to MATCH.
REQ-013 SHALL have port reset_out  output  1  high while in CLEAR.
REQ-014 SHALL have port seq_err  output  1  one-cycle pulse on aborted sequence.
REQ-015 SHALL have port busy  output  1  high while in COLLECT.

Function
REQ-016 SHALL implement states IDLE, COLLECT, MATCH, CLEAR; all outputs registered.
REQ-017 SHALL keep a NUM_ITEMS candidate mask and a position counter idx (width clog2(SEQ_LEN)+1).
REQ-018 Start key (IDLE/MATCH/CLEAR): key_valid with key equal to position 0 of any item -> mask = items matching; idx=1; COLLECT; if SEQ_LEN=1 -> MATCH directly.
REQ-019 In COLLECT, key_valid with non-clear key -> mask &= items whose position idx equals key; zero result -> IDLE plus seq_err pulse; else idx+1.
REQ-020 When idx reaches SEQ_LEN with nonzero mask -> MATCH; item_sel = lowest-index set bit of mask; item_valid pulses for exactly that cycle.
REQ-021 In MATCH, item_sel held until next start key (-> COLLECT, item_sel=0) or clear key; other keys ignored.
REQ-022 CLR_KEY with key_valid in any state -> CLEAR, mask cleared, item_sel=0; clear key takes priority over code matching.
REQ-023 In CLEAR, reset_out=1; exits only on a start key; other keys ignored.
REQ-024 In IDLE, non-start, non-clear keys ignored; no seq_err.
REQ-025 Timeout counter clears on every key_valid and on COLLECT entry; reaching TIMEOUT_CYC in COLLECT -> IDLE plus seq_err pulse.
REQ-026 key_valid in the same cycle as timeout expiry: key processed, timeout ignored.
REQ-027 busy=1 exactly when state is COLLECT.

Reset
REQ-028 clr_n=0 SHALL immediately force IDLE, mask=0, idx=0, counter=0, and all outputs 0, including mid-sequence.
REQ-029 Key strobes after clr_n deasserts SHALL be processed from the first rising edge.

Structure
REQ-030 Package vend_pkg SHALL hold the state encoding, default CLR_KEY and default 4-item code table.
REQ-031 Sub-module vend_timeout (clear, enable, expire) SHALL implement the inter-key counter.

Verification (defaults; table item0={000111,001011}, item1={001101,010111}, item2={011011,011101}, item3={100111,101011})
REQ-032 000111 then 001011 -> item_valid pulse once, item_sel=0001 held, busy 1 then 0.
REQ-033 011011 then 101011 -> IDLE, seq_err one pulse, item_sel=0000.
REQ-034 100111, then no key for TIMEOUT_CYC cycles -> seq_err pulse at expiry, IDLE; key on expiry cycle instead -> processed, no seq_err.
REQ-035 In MATCH(0100), press 110111 -> reset_out=1, item_sel=0000; press 001101,010111 -> reset_out=0, item_sel=0010.
REQ-036 clr_n low after first key 001101 -> all outputs 0 at once; next 010111 alone -> ignored, stays IDLE.
